// File: rtl/dmem_access_unit.sv
// ============================================================================
// Module   : dmem_access_unit
// Purpose  : RV32I load/store front end for a word-addressed data memory with
//            sub-word read-modify-write stores and extended, registered loads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_access_unit #(
   parameter int N  = 32,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_load,
   input  logic          req_store,
   input  logic [2:0]    funct3,
   input  logic [31:0]   addr,
   input  logic [N-1:0]  wdata,
   output logic          stall,
   output logic [N-1:0]  rd_data,
   output logic          rd_valid,
   output logic          misalign_err,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [N-1:0]  mem_wdata,
   input  logic [N-1:0]  mem_rdata
);

   localparam logic [2:0] C_F3_B  = 3'b000;
   localparam logic [2:0] C_F3_H  = 3'b001;
   localparam logic [2:0] C_F3_W  = 3'b010;
   localparam logic [2:0] C_F3_BU = 3'b100;
   localparam logic [2:0] C_F3_HU = 3'b101;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_RMW_WR = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [N-1:0]  r_merge;

   logic          w_store;
   logic          w_load;
   logic          w_is_b;
   logic          w_is_h;
   logic          w_is_w;
   logic          w_is_bu;
   logic          w_is_hu;
   logic          w_range_err;
   logic          w_align_err;
   logic          w_f3_err;
   logic          w_err;
   logic          w_load_go;
   logic          w_capture;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [N-1:0]  w_load_ext;
   logic [N-1:0]  w_merged;

   // Store wins when both requests are raised together.
   assign w_store = req_store;
   assign w_load  = req_load & ~req_store;

   assign w_is_b  = (funct3 == C_F3_B);
   assign w_is_h  = (funct3 == C_F3_H);
   assign w_is_w  = (funct3 == C_F3_W);
   assign w_is_bu = (funct3 == C_F3_BU);
   assign w_is_hu = (funct3 == C_F3_HU);

   assign w_range_err = (addr >> (AW + 2)) != 32'd0;
   assign w_align_err = (w_is_w & (addr[1:0] != 2'b00)) |
                        ((w_is_h | w_is_hu) & addr[0]);
   assign w_f3_err    = w_store ? ~(w_is_b | w_is_h | w_is_w)
                                : ~(w_is_b | w_is_h | w_is_w | w_is_bu | w_is_hu);
   assign w_err       = (w_store | w_load) & (w_range_err | w_align_err | w_f3_err);

   assign mem_addr = addr[AW+1:2];

   always_comb begin
      w_byte = 8'd0;
      case (addr[1:0])
         2'd0:    w_byte = mem_rdata[7:0];
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
      w_half = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      w_load_ext = mem_rdata;
      case (funct3)
         C_F3_B:  w_load_ext = {{24{w_byte[7]}}, w_byte};
         C_F3_H:  w_load_ext = {{16{w_half[15]}}, w_half};
         C_F3_BU: w_load_ext = {24'd0, w_byte};
         C_F3_HU: w_load_ext = {16'd0, w_half};
         default: w_load_ext = mem_rdata;
      endcase
   end

   // Lane replacement relies on the request being held stable through RMW_WR.
   always_comb begin
      w_merged = r_merge;
      if (w_is_b) begin
         case (addr[1:0])
            2'd0:    w_merged[7:0]   = wdata[7:0];
            2'd1:    w_merged[15:8]  = wdata[7:0];
            2'd2:    w_merged[23:16] = wdata[7:0];
            default: w_merged[31:24] = wdata[7:0];
         endcase
      end else if (w_is_h) begin
         if (addr[1]) begin
            w_merged[31:16] = wdata[15:0];
         end else begin
            w_merged[15:0]  = wdata[15:0];
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      stall     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_wdata = '0;
      w_load_go = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_err) begin
               if (w_store) begin
                  if (w_is_w) begin
                     mem_write = 1'b1;
                     mem_wdata = wdata;
                  end else begin
                     mem_read  = 1'b1;
                     stall     = 1'b1;
                     w_capture = 1'b1;
                     w_next    = S_RMW_WR;
                  end
               end else if (w_load) begin
                  mem_read  = 1'b1;
                  w_load_go = 1'b1;
               end
            end
         end
         S_RMW_WR: begin
            mem_write = 1'b1;
            mem_wdata = w_merged;
            w_next    = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      // Keep the memory strobes quiet for the whole time reset is held.
      if (rst) begin
         stall     = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         mem_wdata = '0;
         w_load_go = 1'b0;
         w_capture = 1'b0;
         w_next    = S_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_merge      <= '0;
         rd_data      <= '0;
         rd_valid     <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         r_state      <= w_next;
         rd_valid     <= w_load_go;
         misalign_err <= (r_state == S_IDLE) & w_err;
         if (w_capture) begin
            r_merge <= mem_rdata;
         end
         if (w_load_go) begin
            rd_data <= w_load_ext;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
// ============================================================================
// Module   : tb_dmem_access_unit
// Purpose  : Directed, table-driven self-checking bench for dmem_access_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_access_unit;

   logic        clk;
   logic        rst;
   logic        req_load;
   logic        req_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        misalign_err;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [64];

   int n_cmp  = 0;
   int n_fail = 0;

   dmem_access_unit #(.N(32), .AW(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_load     (req_load),
      .req_store    (req_store),
      .funct3       (funct3),
      .addr         (addr),
      .wdata        (wdata),
      .stall        (stall),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .misalign_err (misalign_err),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
   end

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic        e_mr;
      logic        e_mw;
      logic        e_rmw;
      logic [31:0] e_wd;
      logic        e_v;
      logic [31:0] e_rd;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic ld, logic st, logic [2:0] f3, logic [31:0] a,
                               logic [31:0] wd, logic e_mr, logic e_mw, logic e_rmw,
                               logic [31:0] e_wd, logic e_v, logic [31:0] e_rd,
                               logic e_err);
      vec_t v;
      v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.wd = wd;
      v.e_mr = e_mr; v.e_mw = e_mw; v.e_rmw = e_rmw; v.e_wd = e_wd;
      v.e_v = e_v; v.e_rd = e_rd; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      req_load  = 1'b0;
      req_store = 1'b0;
      funct3    = 3'b000;
      addr      = 32'd0;
      wdata     = 32'd0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      mem[0] = 32'd17;
      mem[1] = 32'd9;

      //        ld st f3      addr          wdata          mr mw rmw e_wdata       v  rd_data       err
      vecs.push_back(mk(1, 0, 3'b010, 32'd0,        32'd0,        1, 0, 0, 32'd0,        1, 32'h00000011, 0));
      vecs.push_back(mk(0, 1, 3'b000, 32'd5,        32'h000000AB, 1, 0, 1, 32'h0000AB09, 0, 32'd0,        0));
      vecs.push_back(mk(1, 0, 3'b000, 32'd5,        32'd0,        1, 0, 0, 32'd0,        1, 32'hFFFFFFAB, 0));
      vecs.push_back(mk(1, 0, 3'b100, 32'd5,        32'd0,        1, 0, 0, 32'd0,        1, 32'h000000AB, 0));
      vecs.push_back(mk(0, 1, 3'b001, 32'd6,        32'h1234F00D, 1, 0, 1, 32'hF00DAB09, 0, 32'd0,        0));
      vecs.push_back(mk(1, 0, 3'b001, 32'd6,        32'd0,        1, 0, 0, 32'd0,        1, 32'hFFFFF00D, 0));
      vecs.push_back(mk(1, 0, 3'b101, 32'd6,        32'd0,        1, 0, 0, 32'd0,        1, 32'h0000F00D, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'd2,        32'd0,        0, 0, 0, 32'd0,        0, 32'd0,        1));
      vecs.push_back(mk(0, 1, 3'b001, 32'd3,        32'h00005555, 0, 0, 0, 32'd0,        0, 32'd0,        1));
      vecs.push_back(mk(1, 0, 3'b010, 32'h100,      32'd0,        0, 0, 0, 32'd0,        0, 32'd0,        1));
      vecs.push_back(mk(1, 1, 3'b010, 32'd8,        32'hDEADBEEF, 0, 1, 0, 32'hDEADBEEF, 0, 32'd0,        0));
      vecs.push_back(mk(1, 0, 3'b010, 32'd8,        32'd0,        1, 0, 0, 32'd0,        1, 32'hDEADBEEF, 0));
      vecs.push_back(mk(1, 0, 3'b000, 32'd4,        32'd0,        1, 0, 0, 32'd0,        1, 32'h00000009, 0));
      vecs.push_back(mk(1, 0, 3'b001, 32'd4,        32'd0,        1, 0, 0, 32'd0,        1, 32'hFFFFAB09, 0));
      vecs.push_back(mk(1, 0, 3'b011, 32'd0,        32'd0,        0, 0, 0, 32'd0,        0, 32'd0,        1));
      vecs.push_back(mk(0, 1, 3'b100, 32'd1,        32'h00000077, 0, 0, 0, 32'd0,        0, 32'd0,        1));
      vecs.push_back(mk(1, 0, 3'b110, 32'd4,        32'd0,        0, 0, 0, 32'd0,        0, 32'd0,        1));
      vecs.push_back(mk(1, 0, 3'b011, 32'd0,        32'd0,        0, 0, 0, 32'd0,        0, 32'd0,        1));
      vecs.push_back(mk(1, 0, 3'b000, 32'd4,        32'd0,        1, 0, 0, 32'd0,        1, 32'h00000009, 0));
      vecs.push_back(mk(1, 0, 3'b000, 32'd7,        32'd0,        1, 0, 0, 32'd0,        1, 32'hFFFFFFF0, 0));

      idle_inputs();
      rst = 1'b1;
      #12;
      chk("reset_stall",     {31'd0, stall},        32'd0);
      chk("reset_rd_data",   rd_data,               32'd0);
      chk("reset_rd_valid",  {31'd0, rd_valid},     32'd0);
      chk("reset_misalign",  {31'd0, misalign_err}, 32'd0);
      chk("reset_mem_write", {31'd0, mem_write},    32'd0);
      chk("reset_mem_wdata", mem_wdata,             32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      foreach (vecs[k]) begin
         req_load  = vecs[k].ld;
         req_store = vecs[k].st;
         funct3    = vecs[k].f3;
         addr      = vecs[k].a;
         wdata     = vecs[k].wd;
         #2;
         chk($sformatf("v%0d_mem_read", k),  {31'd0, mem_read},  {31'd0, vecs[k].e_mr});
         chk($sformatf("v%0d_mem_write", k), {31'd0, mem_write}, {31'd0, vecs[k].e_mw});
         chk($sformatf("v%0d_stall", k),     {31'd0, stall},     {31'd0, vecs[k].e_rmw});
         chk($sformatf("v%0d_mem_addr", k),  {26'd0, mem_addr},  {26'd0, vecs[k].a[7:2]});
         if (vecs[k].e_mw)
            chk($sformatf("v%0d_mem_wdata", k), mem_wdata, vecs[k].e_wd);
         if (vecs[k].e_rmw) begin
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rmw_stall", k),  {31'd0, stall},     32'd0);
            chk($sformatf("v%0d_rmw_read", k),   {31'd0, mem_read},  32'd0);
            chk($sformatf("v%0d_rmw_write", k),  {31'd0, mem_write}, 32'd1);
            chk($sformatf("v%0d_rmw_wdata", k),  mem_wdata,          vecs[k].e_wd);
            chk($sformatf("v%0d_rmw_valid", k),  {31'd0, rd_valid},  32'd0);
         end
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_rd_valid", k), {31'd0, rd_valid},     {31'd0, vecs[k].e_v});
         chk($sformatf("v%0d_misalign", k), {31'd0, misalign_err}, {31'd0, vecs[k].e_err});
         if (vecs[k].e_v)
            chk($sformatf("v%0d_rd_data", k), rd_data, vecs[k].e_rd);
         if (k == 9) begin
            // Byte 3 of word 1 is set up here for the final LB vector.
            mem[1][31:24] = 8'hF0;
         end
      end

      idle_inputs();
      @(posedge clk);
      #1;
      chk("idle_rd_valid", {31'd0, rd_valid},     32'd0);
      chk("idle_misalign", {31'd0, misalign_err}, 32'd0);
      chk("mem2_after_sw", mem[2],                32'hDEADBEEF);
      chk("mem1_merged",   mem[1],                32'hF00DAB09);

      // Reset in the RMW_WR cycle must abort the write.
      req_store = 1'b1;
      funct3    = 3'b000;
      addr      = 32'd0;
      wdata     = 32'h00000055;
      #2;
      chk("rstrmw_stall0", {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1;
      chk("rstrmw_write_before", {31'd0, mem_write}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rstrmw_write_drop", {31'd0, mem_write},    32'd0);
      chk("rstrmw_stall",      {31'd0, stall},        32'd0);
      chk("rstrmw_read",       {31'd0, mem_read},     32'd0);
      chk("rstrmw_wdata",      mem_wdata,             32'd0);
      chk("rstrmw_rd_data",    rd_data,               32'd0);
      chk("rstrmw_rd_valid",   {31'd0, rd_valid},     32'd0);
      chk("rstrmw_misalign",   {31'd0, misalign_err}, 32'd0);
      @(posedge clk);
      #1;
      chk("rstrmw_mem0", mem[0], 32'd17);
      idle_inputs();
      rst = 1'b0;
      @(posedge clk);
      #1;
      // FSM must be back in IDLE: a plain SW commits in a single cycle.
      req_store = 1'b1;
      funct3    = 3'b010;
      addr      = 32'd12;
      wdata     = 32'hCAFEF00D;
      #2;
      chk("post_rst_sw_write", {31'd0, mem_write}, 32'd1);
      chk("post_rst_sw_stall", {31'd0, stall},     32'd0);
      @(posedge clk);
      #1;
      idle_inputs();
      chk("post_rst_mem3", mem[3], 32'hCAFEF00D);
      req_load = 1'b1;
      funct3   = 3'b010;
      addr     = 32'd0;
      @(posedge clk);
      #1;
      chk("post_rst_lw_valid", {31'd0, rd_valid}, 32'd1);
      chk("post_rst_lw_data",  rd_data,           32'h00000011);
      idle_inputs();
      @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Sits between the EX/MEM pipeline register and the word-addressed data memory. The memory has a 6-bit word address, an asynchronous read, and a synchronous full-word write.
- Converts RV32I byte-addressed loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
- Sub-word stores are done as a 2-cycle read-modify-write. Load data is sign- or zero-extended and registered for the MEM/WB stage.
- Raises a stall while a read-modify-write is in flight. Flags misaligned and out-of-range accesses.

Parameters:
- n, 32, data width; fixed at 32 for RV32I.
- AW, 6, memory word-address width; the usable byte range is 0 to 4*2^AW-1.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- req_load  input  1  load request from the MEM stage.
- req_store  input  1  store request from the MEM stage.
- funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  32  byte address.
- wdata  input  n  store data (rs2).
- stall  output  1  freezes the upstream pipeline; the request must be held stable while stall=1.
- rd_data  output  n  registered, extended load result.
- rd_valid  output  1  one-cycle pulse: rd_data is valid.
- misalign_err  output  1  registered one-cycle pulse.
- mem_read  output  1  to memory MemRead.
- mem_write  output  1  to memory MemWrite.
- mem_addr  output  AW  memory word address = addr[AW+1:2].
- mem_wdata  output  n  to memory data_in.
- mem_rdata  input  n  from memory data_out; asynchronous.

Behaviour:
- Reset, asynchronous: FSM goes to IDLE. stall, rd_data, rd_valid, misalign_err, mem_read, mem_write, mem_wdata and the merge register all go to 0.
- Error check, combinational:
  - err = addr[31:AW+2] != 0
  - or W with addr[1:0] != 0
  - or H/HU with addr[0] = 1
  - or an undefined funct3 (011, 110, 111; BU/HU are also undefined for stores).
  - On err: no mem_read and no mem_write. misalign_err pulses the next cycle. rd_valid stays 0.
- If req_load and req_store are both asserted, the store wins and the load is ignored.
- FSM states are IDLE and RMW_WR.
- IDLE, load (no err):
  - mem_read=1 this cycle.
  - Next edge: rd_data <= extract(mem_rdata, addr[1:0]) with extension; rd_valid <= 1.
  - Byte select uses addr[1:0]; halfword select uses addr[1].
  - B/H sign-extend; BU/HU zero-extend.
  - stall=0.
- IDLE, SW (no err):
  - mem_write=1, mem_wdata=wdata, in the same cycle.
  - Single cycle, stall=0.
- IDLE, SB/SH (no err):
  - mem_read=1 and stall=1.
  - Next edge: merge_reg <= mem_rdata; go to RMW_WR.
- RMW_WR:
  - mem_write=1 and stall=0.
  - mem_wdata = merge_reg with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Next edge: go to IDLE.
  - Net latency: 2 cycles, with 1 stall cycle.
- rd_valid and misalign_err are 0 in every cycle not described above.
- mem_addr always tracks addr[AW+1:2], including in error cycles; mem_read and mem_write gate the access.
- Reset asserted in RMW_WR: mem_write drops immediately (combinational from state) and the memory word is left unmodified.
- A back-to-back request in the cycle after RMW_WR is accepted normally.
- A load immediately after a sub-word store to the same word returns the merged value, because the write commits at the RMW_WR edge.

Test Plan:
- Memory preloaded mem[0]=17, mem[1]=9. LW addr=0 -> mem_read=1, next cycle rd_data=0x00000011, rd_valid=1, stall never high.
- SB addr=5 wdata=0xAB over word1=0x00000009:
  - cycle 0: stall=1, mem_read=1.
  - cycle 1: mem_write=1, mem_wdata=0x0000AB09.
  - then LB addr=5 -> rd_data=0xFFFFFFAB.
  - then LBU addr=5 -> rd_data=0x000000AB.
- SH addr=6 wdata=0x1234F00D into word1=0x0000AB09 -> mem_wdata=0xF00DAB09; then LH addr=6 -> 0xFFFFF00D, LHU addr=6 -> 0x0000F00D.
- Misalignment and range:
  - LW addr=2 -> no mem_read, misalign_err pulse next cycle, rd_valid=0.
  - SH addr=3 -> no mem_write, misalign_err pulse.
  - LW addr=0x100 -> misalign_err pulse.
- Assert rst during the RMW_WR cycle of SB addr=0 -> mem_write=0, mem[0] stays 17, all outputs 0, FSM in IDLE.
- req_load=req_store=1, SW addr=8 wdata=0xDEADBEEF -> mem_write=1 and mem[2]=0xDEADBEEF; rd_valid=0.
